// File: rtl/conv_mac_engine_if.sv
// conv_mac_engine_if: beat-in / result-out valid-ready bundle for conv_mac_engine
interface conv_mac_engine_if #(
    parameter int INT_BITS  = 2,
    parameter int FRAC_BITS = 14,
    parameter int NUM_MACS  = 16,
    parameter int KERNEL    = 3
);
    localparam int DATA_W = INT_BITS + FRAC_BITS;
    localparam int TAPS   = KERNEL * KERNEL;
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_first;
    logic                            in_last;
    logic                            in_mode;
    logic [NUM_MACS*TAPS*DATA_W-1:0] in_data;
    logic [NUM_MACS*TAPS*DATA_W-1:0] in_weight;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_MACS*DATA_W-1:0]      out_data;
    logic                            out_mode;
    logic [NUM_MACS-1:0]             out_sat;
    modport master (
        output in_valid, in_first, in_last, in_mode, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_sat
    );
    modport slave (
        input  in_valid, in_first, in_last, in_mode, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_sat
    );
endinterface

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: pipelined KxK MAC lanes with multi-beat accumulation, optional lane reduction and round/saturate; CONV_MAC_RELU_EN adds ReLU on results
module conv_mac_engine #(
    parameter int INT_BITS  = 2,
    parameter int FRAC_BITS = 14,
    parameter int NUM_MACS  = 16,
    parameter int KERNEL    = 3,
    parameter int ACC_GUARD = 8
) (
    input logic              clk,
    input logic              rst_n,
    conv_mac_engine_if.slave bus
);
    localparam int DATA_W = INT_BITS + FRAC_BITS;
    localparam int TAPS   = KERNEL * KERNEL;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(TAPS);
    localparam int ACC_W  = SUM_W + $clog2(NUM_MACS) + ACC_GUARD;
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W:0] HI   = ((ACC_W+1)'(1) << (DATA_W - 1)) - (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] LO   = ~HI;

    logic stall, take, eff_mode, mode_lat;
    logic s0_valid, s0_first, s0_last, s0_mode;
    logic s1_valid, s1_first, s1_last, s1_mode;
    logic s2_valid, s2_first, s2_last, s2_mode;
    logic [NUM_MACS*TAPS*DATA_W-1:0] s0_data, s0_weight;
    logic signed [PROD_W-1:0] prod   [NUM_MACS][TAPS];
    logic signed [PROD_W-1:0] s1_prod [NUM_MACS][TAPS];
    logic signed [SUM_W-1:0]  tap_sum [NUM_MACS];
    logic signed [SUM_W-1:0]  s2_sum  [NUM_MACS];
    logic signed [ACC_W-1:0]  acc      [NUM_MACS];
    logic signed [ACC_W-1:0]  acc_next [NUM_MACS];
    logic signed [ACC_W-1:0]  lane_total;
    logic [NUM_MACS-1:0][DATA_W-1:0] res;
    logic [NUM_MACS-1:0]             sat;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall & rst_n;
    assign take         = bus.in_valid & bus.in_ready;
    assign eff_mode     = bus.in_first ? bus.in_mode : mode_lat;

    for (genvar i = 0; i < NUM_MACS; i++) begin : g_lane
        for (genvar t = 0; t < TAPS; t++) begin : g_tap
            assign prod[i][t] = $signed(s0_data[(i*TAPS+t)*DATA_W +: DATA_W]) *
                                $signed(s0_weight[(i*TAPS+t)*DATA_W +: DATA_W]);
        end
    end

    // Sign-extended sum of the registered products in each lane
    always_comb begin
        for (int i = 0; i < NUM_MACS; i++) begin
            tap_sum[i] = '0;
            for (int t = 0; t < TAPS; t++) tap_sum[i] += SUM_W'(s1_prod[i][t]);
        end
    end

    // Next accumulator value; reduce mode folds every lane sum into lane 0
    always_comb begin
        lane_total = '0;
        for (int i = 0; i < NUM_MACS; i++) lane_total += ACC_W'(s2_sum[i]);
        for (int i = 0; i < NUM_MACS; i++)
            acc_next[i] = (s2_mode && i != 0) ? '0 :
                          (s2_first ? '0 : acc[i]) + (s2_mode ? lane_total : ACC_W'(s2_sum[i]));
    end

    // Round half up, clamp to the data word, optionally drop negative results
    always_comb begin
        logic signed [ACC_W:0] sh;
        for (int i = 0; i < NUM_MACS; i++) begin
            sh     = $signed({acc_next[i][ACC_W-1], acc_next[i]} + HALF) >>> FRAC_BITS;
            sat[i] = (sh > HI) || (sh < LO);
            res[i] = sh > HI ? HI[DATA_W-1:0] : sh < LO ? LO[DATA_W-1:0] : sh[DATA_W-1:0];
`ifdef CONV_MAC_RELU_EN
            res[i] = res[i][DATA_W-1] ? '0 : res[i];
`endif
        end
    end

    // Advance all stages in lockstep unless the result register is blocked downstream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid      <= 1'b0;
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            mode_lat      <= 1'b0;
            acc           <= '{default: '0};
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_mode  <= 1'b0;
            bus.out_sat   <= '0;
        end else if (!stall) begin
            s0_valid  <= take;
            s0_first  <= bus.in_first;
            s0_last   <= bus.in_last;
            s0_mode   <= eff_mode;
            s0_data   <= bus.in_data;
            s0_weight <= bus.in_weight;
            if (take) mode_lat <= eff_mode;
            s1_valid  <= s0_valid;
            s1_first  <= s0_first;
            s1_last   <= s0_last;
            s1_mode   <= s0_mode;
            s1_prod   <= prod;
            s2_valid  <= s1_valid;
            s2_first  <= s1_first;
            s2_last   <= s1_last;
            s2_mode   <= s1_mode;
            s2_sum    <= tap_sum;
            if (s2_valid) acc <= acc_next;
            bus.out_valid <= s2_valid & s2_last;
            if (s2_valid && s2_last) begin
                bus.out_data <= res;
                bus.out_mode <= s2_mode;
                bus.out_sat  <= sat;
            end
        end
    end
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: directed self-checking bench for conv_mac_engine
module tb_conv_mac_engine;
    localparam int DW   = 16;
    localparam int TAPS = 9;
`ifdef CONV_MAC_RELU_EN
    localparam logic [15:0] NEG_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG_EXP = 16'hDC00;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int n_out = 0;
    int base;
    logic [15:0] seen [$];

    conv_mac_engine_if bus ();
    conv_mac_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Count every result handshake
    always @(posedge clk) if (rst_n && bus.out_valid && bus.out_ready) n_out++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic f, input logic l, input logic m, input logic [15:0] d,
                        input logic [15:0] w, input int nl, input int nt);
        bus.in_data   = '0;
        bus.in_weight = '0;
        for (int i = 0; i < nl; i++)
            for (int t = 0; t < nt; t++) begin
                bus.in_data[(i*TAPS+t)*DW +: DW]   = d;
                bus.in_weight[(i*TAPS+t)*DW +: DW] = w;
            end
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [15:0] lane0,
                             input logic [15:0] sat, input logic mode);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_lane0"}, bus.out_data[15:0], lane0);
        chk({tag, "_rest"}, bus.out_data >> 16, 0);
        chk({tag, "_sat"}, bus.out_sat, sat);
        chk({tag, "_mode"}, bus.out_mode, mode);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_out_mode", bus.out_mode, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);

        beat(1, 1, 0, 16'h1000, 16'h1000, 1, TAPS);
        chk("lat_t0", bus.out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("lat_t2", bus.out_valid, 0);
        @(negedge clk);
        check_res("single_pos", 16'h2400, 16'h0000, 0);

        beat(1, 1, 0, 16'hF000, 16'h1000, 1, TAPS);
        check_res("single_neg", NEG_EXP, 16'h0000, 0);

        base = n_out;
        beat(1, 0, 0, 16'h1000, 16'h1000, 1, TAPS);
        beat(0, 0, 1, 16'h1000, 16'h1000, 1, TAPS);
        beat(0, 1, 1, 16'h1000, 16'h1000, 1, TAPS);
        check_res("multi_beat", 16'h6C00, 16'h0000, 0);
        repeat (5) @(negedge clk);
        chk("multi_one_out", n_out - base, 1);

        beat(1, 1, 1, 16'h1000, 16'h1000, 16, TAPS);
        check_res("reduce_sat", 16'h7FFF, 16'h0001, 1);

        beat(1, 1, 0, 16'h0001, 16'h2000, 1, 1);
        check_res("round", 16'h0001, 16'h0000, 0);

        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("bp_accept", bus.in_ready, 1);
            beat(1, 1, 0, 16'h1000, 16'h1000, 1, k);
        end
        for (int c = 0; c < 5; c++) begin
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_hold", bus.out_data[15:0], 16'h0400);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) seen.push_back(bus.out_data[15:0]);
            @(negedge clk);
        end
        chk("bp_count", seen.size(), 4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk("bp_order", seen[k], 16'((k + 1) * 16'h0400));

        beat(1, 1, 0, 16'h1000, 16'h1000, 1, 1);
        beat(1, 1, 0, 16'h1000, 16'h1000, 1, 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        base = n_out;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_stale", n_out - base, 0);
        chk("midrst_idle", bus.out_valid, 0);

        beat(1, 1, 0, 16'h1000, 16'h1000, 1, TAPS);
        check_res("post_rst", 16'h2400, 16'h0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
- Parametrised, pipelined MAC array for the CNN datapath. Each lane computes a K×K dot product of an ifmap window against weights.
- Lanes either stay independent (per-lane outputs) or are reduced to one scalar.
- Results can be accumulated across multiple input-channel beats using first/last framing.
- Valid/ready handshake on both sides. Sits between the window/weight fetch logic and the ofmap writeback.

Parameters:
- INT_BITS, 2, integer bits of the signed fixed-point word, sign included.
- FRAC_BITS, 14, fractional bits; DATA_W = INT_BITS+FRAC_BITS.
- NUM_MACS, 16, parallel MAC lanes.
- KERNEL, 3, kernel side; TAPS = KERNEL*KERNEL.
- ACC_GUARD, 8, extra accumulator bits for multi-beat accumulation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  engine accepts a beat this cycle
- in_first  in  1  beat starts a new accumulation (clears accumulators)
- in_last  in  1  beat ends accumulation (produces a result)
- in_mode  in  1  0 = per-lane outputs, 1 = reduce all lanes; sampled only on in_first beats
- in_data  in  NUM_MACS*TAPS*DATA_W  windows, lane-major, tap 0 in LSBs
- in_weight  in  NUM_MACS*TAPS*DATA_W  weights, same packing
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  NUM_MACS*DATA_W  results, lane 0 in LSBs
- out_mode  out  1  mode the result was produced in
- out_sat  out  NUM_MACS  per-lane saturation flag

Behaviour:
- Reset (rst_n=0 at a clock edge): in_ready=0 during reset, 1 the cycle after release.
  - Cleared to 0: out_valid, out_data, out_mode, out_sat, all stage valids, all accumulators and the latched mode.
  - Reset mid-operation discards all in-flight beats and partial sums.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall & rst_n. All stages hold while stall=1; out_* stay stable.
- Beat accepted when in_valid & in_ready.
- Pipeline:
  - S1 registers TAPS signed products per lane (2*DATA_W bits, Q with 2*FRAC_BITS fraction).
  - S2 registers the per-lane tap sum (sign-extended adder tree).
  - S3 updates the accumulators (ACC_W = 2*DATA_W + clog2(TAPS) + clog2(NUM_MACS) + ACC_GUARD):
    - first beat: acc = sum; otherwise acc += sum.
    - mode 1: only acc lane 0 is used, and it adds the sum of all lane sums.
  - On a last beat, S3 also loads the output register with round/saturate of the new acc value, and sets out_valid.
- Latency: a last beat accepted at edge T gives out_valid=1 after edge T+3 when there is no stall. Non-last beats produce no output.
- Throughput: one beat per cycle. A result handshake and a new result arriving on the same edge reload the output without a bubble.
- Round and saturate:
  - Round half up: add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat[i]=1 when a lane clamped.
- Mode 1 output: result in lane 0; lanes 1..NUM_MACS-1 of out_data and out_sat are 0.
- Framing:
  - in_first & in_last on the same beat is a single-pass result.
  - A non-first beat continues the existing accumulation.
  - in_mode on non-first beats is ignored.
- in_data/in_weight are don't-care when in_valid=0.

Optional Feature:
- Macro: CONV_MAC_RELU_EN.
- Defined: after saturation, negative lane results are forced to 0, and out_sat still reflects the pre-ReLU clamp.
- Undefined: signed results pass unchanged and no ReLU logic is synthesised.

Test Plan:
- Mode 0, single beat (first=last=1), lane 0 all data 0x1000 and weights 0x1000, other lanes 0 -> 3 cycles later out_data lane0=0x2400, other lanes 0, out_sat=0.
- Same stimulus with lane 0 data 0xF000 -> lane0=0xDC00; with CONV_MAC_RELU_EN defined -> lane0=0x0000.
- Three beats (first, mid, last) of the 0x1000/0x1000 lane-0 stimulus -> exactly one output, lane0=0x6C00, after the third beat +3 cycles.
- Mode 1, all 16 lanes 0x1000/0x1000, single beat -> lane0 exact sum 9.0 saturates to 0x7FFF, out_sat[0]=1, other lanes 0, out_mode=1.
- Rounding: lane 0 tap 0 data 0x0001, weight 0x2000, other taps 0 -> lane0=0x0001.
- Backpressure: stream 4 single-beat results with out_ready=0 for 5 cycles -> in_ready drops once out_valid=1, out_data held stable, all 4 results delivered in order with none lost or duplicated; reset pulse mid-stream -> out_valid=0 next cycle and no stale results after release.
